// File: rtl/pkt_gen_mc.sv
// pkt_gen_mc: multi-channel packet generator.
// NUM_CH CPU-side sources each feed a FIFO of FIFO_DEPTH entries. A round-robin
// arbiter issues at most one packet per cycle onto the shared TX bus. Each
// channel needs a credit to issue; credits are replenished by credit_ret.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cpu_valid/cpu_ready      per-channel push handshake
//   cpu_data/flags/proc_id   per-channel packet fields, channel c at [c*W +: W]
//   credit_ret               per-channel credit return, one credit per bit per cycle
//   tx_valid/payload/flags/addr/ecc/id/eop/ch   registered packet bus outputs
//   credit_err               sticky per-channel credit overflow flag
// Optional macro PKT_GEN_MC_SEQ_EN adds tx_seq, a per-channel 8-bit issue counter.
module pkt_gen_mc #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned FLAGS_W     = 4,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned ID_W        = 4,
  parameter int unsigned PKT_PROC_ID = 0,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned MAX_CREDIT  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           cpu_valid,
  output logic [NUM_CH-1:0]           cpu_ready,
  input  logic [NUM_CH*DATA_W-1:0]    cpu_data,
  input  logic [NUM_CH*FLAGS_W-1:0]   cpu_flags,
  input  logic [NUM_CH*ADDR_W-1:0]    cpu_proc_id,
  input  logic [NUM_CH-1:0]           credit_ret,
  output logic                        tx_valid,
  output logic [DATA_W-1:0]           tx_payload,
  output logic [FLAGS_W-1:0]          tx_flags,
  output logic [ADDR_W-1:0]           tx_addr,
  output logic                        tx_ecc,
  output logic [ID_W-1:0]             tx_id,
  output logic                        tx_eop,
  output logic [$clog2(NUM_CH)-1:0]   tx_ch,
  output logic [NUM_CH-1:0]           credit_err
`ifdef PKT_GEN_MC_SEQ_EN
  ,
  output logic [7:0]                  tx_seq
`endif
);

  localparam int unsigned CH_W     = $clog2(NUM_CH);
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CREDIT_W = $clog2(MAX_CREDIT + 1);
  localparam int unsigned ENTRY_W  = DATA_W + FLAGS_W + ADDR_W;

  logic [ENTRY_W-1:0]  mem    [NUM_CH][FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr [NUM_CH];
  logic [PTR_W-1:0]    rd_ptr [NUM_CH];
  logic [PTR_W:0]      count  [NUM_CH];
  logic [CREDIT_W-1:0] credit [NUM_CH];
  logic [CH_W-1:0]     rr_ptr;

  logic [NUM_CH-1:0]   push;
  logic [NUM_CH-1:0]   pop;
  logic [NUM_CH-1:0]   eligible;
  logic                grant_valid;
  logic [CH_W-1:0]     grant_ch;
  logic [ENTRY_W-1:0]  head;

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      cpu_ready[c] = (count[c] != (PTR_W+1)'(FIFO_DEPTH));
      push[c]      = cpu_valid[c] & cpu_ready[c];
      eligible[c]  = (count[c] != '0) && (credit[c] != '0);
    end
  end

  // Scan channels starting at rr_ptr; the first eligible one wins.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_ch    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = (32'(rr_ptr) + i) % NUM_CH;
      if (!grant_valid && eligible[idx]) begin
        grant_valid = 1'b1;
        grant_ch    = CH_W'(idx);
      end
    end
    pop = '0;
    if (grant_valid) pop[grant_ch] = 1'b1;
    head = mem[grant_ch][rd_ptr[grant_ch]];
  end

  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (push[c]) begin
        mem[c][wr_ptr[c]] <= {cpu_data[c*DATA_W +: DATA_W],
                              cpu_flags[c*FLAGS_W +: FLAGS_W],
                              cpu_proc_id[c*ADDR_W +: ADDR_W]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        count[c]  <= '0;
        credit[c] <= CREDIT_W'(MAX_CREDIT);
      end
      credit_err <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
        case ({push[c], pop[c]})
          2'b10:   count[c] <= count[c] + (PTR_W+1)'(1);
          2'b01:   count[c] <= count[c] - (PTR_W+1)'(1);
          default: ;
        endcase
        // A grant with a same-cycle return nets to zero, so only a lone
        // return at the ceiling counts as an overflow.
        case ({pop[c], credit_ret[c]})
          2'b10: credit[c] <= credit[c] - CREDIT_W'(1);
          2'b01: begin
            if (credit[c] == CREDIT_W'(MAX_CREDIT)) credit_err[c] <= 1'b1;
            else                                    credit[c]     <= credit[c] + CREDIT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      tx_valid   <= 1'b0;
      tx_payload <= '0;
      tx_flags   <= '0;
      tx_addr    <= '0;
      tx_ecc     <= 1'b0;
      tx_ch      <= '0;
    end else begin
      tx_valid <= grant_valid;
      if (grant_valid) begin
        rr_ptr     <= CH_W'((32'(grant_ch) + 1) % NUM_CH);
        tx_payload <= head[ENTRY_W-1 -: DATA_W];
        tx_flags   <= head[FLAGS_W+ADDR_W-1 -: FLAGS_W];
        tx_addr    <= head[ADDR_W-1:0];
        tx_ecc     <= ^head[ENTRY_W-1 -: DATA_W];
        tx_ch      <= grant_ch;
      end
    end
  end

  assign tx_id  = ID_W'(PKT_PROC_ID);
  assign tx_eop = tx_valid;

`ifdef PKT_GEN_MC_SEQ_EN
  logic [7:0] seq_cnt [NUM_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) seq_cnt[c] <= '0;
      tx_seq <= '0;
    end else if (grant_valid) begin
      seq_cnt[grant_ch] <= seq_cnt[grant_ch] + 8'd1;
      tx_seq            <= seq_cnt[grant_ch];
    end
  end
`endif

endmodule

// File: tb/tb_pkt_gen_mc.sv
// Directed bench for pkt_gen_mc: a vector table for basic issue and round-robin
// order, plus hand-written sequences for credits, overflow and reset.
module tb_pkt_gen_mc;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   cpu_valid = '0;
  logic [3:0]   cpu_ready;
  logic [127:0] cpu_data = '0;
  logic [15:0]  cpu_flags = '0;
  logic [31:0]  cpu_proc_id = '0;
  logic [3:0]   credit_ret = '0;
  logic         tx_valid;
  logic [31:0]  tx_payload;
  logic [3:0]   tx_flags;
  logic [7:0]   tx_addr;
  logic         tx_ecc;
  logic [3:0]   tx_id;
  logic         tx_eop;
  logic [1:0]   tx_ch;
  logic [3:0]   credit_err;
`ifdef PKT_GEN_MC_SEQ_EN
  logic [7:0]   tx_seq;
`endif

  int checks = 0;
  int errors = 0;

  pkt_gen_mc #(.NUM_CH(4), .DATA_W(32), .FLAGS_W(4), .ADDR_W(8), .ID_W(4),
               .PKT_PROC_ID(0), .FIFO_DEPTH(4), .MAX_CREDIT(8)) dut (
    .clk(clk), .rst(rst), .cpu_valid(cpu_valid), .cpu_ready(cpu_ready),
    .cpu_data(cpu_data), .cpu_flags(cpu_flags), .cpu_proc_id(cpu_proc_id),
    .credit_ret(credit_ret), .tx_valid(tx_valid), .tx_payload(tx_payload),
    .tx_flags(tx_flags), .tx_addr(tx_addr), .tx_ecc(tx_ecc), .tx_id(tx_id),
    .tx_eop(tx_eop), .tx_ch(tx_ch), .credit_err(credit_err)
`ifdef PKT_GEN_MC_SEQ_EN
    , .tx_seq(tx_seq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        exp_valid;
    logic [1:0]  exp_ch;
    logic [31:0] exp_payload;
    logic [3:0]  exp_ready;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Push up to npush packets on one channel (only when ready), and verify every
  // issued packet comes from that channel with payloads base, base+1, ...
  task automatic drive_ch(input int ch, input int cycles, input int npush,
                          input logic [31:0] base, output int issued);
    int pushed;
    pushed = 0;
    issued = 0;
    for (int i = 0; i < cycles; i++) begin
      if (pushed < npush && cpu_ready[ch]) begin
        cpu_valid = 4'(1 << ch);
        cpu_data[ch*32 +: 32] = base + 32'(pushed);
        pushed++;
      end else begin
        cpu_valid = '0;
      end
      tick();
      if (tx_valid) begin
        check("drive_ch tx_ch", 64'(tx_ch), 64'(ch));
        check("drive_ch payload", 64'(tx_payload), 64'(base + 32'(issued)));
        issued++;
      end
    end
    cpu_valid = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cpu_valid = '0;
    credit_ret = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    for (int c = 0; c < 4; c++) begin
      cpu_flags[c*4 +: 4]   = 4'(c);
      cpu_proc_id[c*8 +: 8] = 8'(8'h40 + c);
    end

    //          rst   valid  data          exp_v ch  payload       ready
    vecs[0]  = '{1'b1, 4'h0, 32'h0,        1'b0, 2'd0, 32'h0,        4'hF};
    vecs[1]  = '{1'b0, 4'h1, 32'hA5A50001, 1'b0, 2'd0, 32'h0,        4'hF};
    vecs[2]  = '{1'b0, 4'h0, 32'h0,        1'b1, 2'd0, 32'hA5A50001, 4'hF};
    vecs[3]  = '{1'b0, 4'h0, 32'h0,        1'b0, 2'd0, 32'h0,        4'hF};
    vecs[4]  = '{1'b1, 4'h0, 32'h0,        1'b0, 2'd0, 32'h0,        4'hF};
    vecs[5]  = '{1'b0, 4'hF, 32'h1000,     1'b0, 2'd0, 32'h0,        4'hF};
    vecs[6]  = '{1'b0, 4'hF, 32'h2000,     1'b1, 2'd0, 32'h1000,     4'hF};
    vecs[7]  = '{1'b0, 4'hF, 32'h3000,     1'b1, 2'd1, 32'h1001,     4'hF};
    vecs[8]  = '{1'b0, 4'hF, 32'h4000,     1'b1, 2'd2, 32'h1002,     4'h7};
    vecs[9]  = '{1'b0, 4'h0, 32'h0,        1'b1, 2'd3, 32'h1003,     4'hF};
    vecs[10] = '{1'b0, 4'h0, 32'h0,        1'b1, 2'd0, 32'h2000,     4'hF};
    vecs[11] = '{1'b0, 4'h0, 32'h0,        1'b1, 2'd1, 32'h2001,     4'hF};
    vecs[12] = '{1'b0, 4'h0, 32'h0,        1'b1, 2'd2, 32'h2002,     4'hF};
    vecs[13] = '{1'b0, 4'h0, 32'h0,        1'b1, 2'd3, 32'h2003,     4'hF};

    for (int v = 0; v < 14; v++) begin
      rst = vecs[v].rst;
      cpu_valid = vecs[v].valid;
      for (int c = 0; c < 4; c++) cpu_data[c*32 +: 32] = vecs[v].data + 32'(c);
      tick();
      check($sformatf("vec%0d tx_valid", v), 64'(tx_valid), 64'(vecs[v].exp_valid));
      check($sformatf("vec%0d cpu_ready", v), 64'(cpu_ready), 64'(vecs[v].exp_ready));
      if (vecs[v].exp_valid) begin
        check($sformatf("vec%0d tx_ch", v), 64'(tx_ch), 64'(vecs[v].exp_ch));
        check($sformatf("vec%0d payload", v), 64'(tx_payload), 64'(vecs[v].exp_payload));
        check($sformatf("vec%0d flags", v), 64'(tx_flags), 64'(vecs[v].exp_ch));
        check($sformatf("vec%0d addr", v), 64'(tx_addr), 64'(8'h40 + 8'(vecs[v].exp_ch)));
      end
    end
    cpu_valid = '0;

    // Reset state, then two-clock latency and parity of a single packet.
    do_reset();
    check("rst tx_valid", 64'(tx_valid), 64'(0));
    check("rst tx_payload", 64'(tx_payload), 64'(0));
    check("rst credit_err", 64'(credit_err), 64'(0));
    cpu_valid = 4'b0001;
    cpu_data[31:0] = 32'hA5A50001;
    tick();
    cpu_valid = '0;
    check("lat edge1 tx_valid", 64'(tx_valid), 64'(0));
    tick();
    check("lat edge2 tx_valid", 64'(tx_valid), 64'(1));
    check("lat payload", 64'(tx_payload), 64'(32'hA5A50001));
    check("lat ecc", 64'(tx_ecc), 64'(1));
    check("lat eop", 64'(tx_eop), 64'(1));
    check("lat tx_id", 64'(tx_id), 64'(0));
    check("lat tx_ch", 64'(tx_ch), 64'(0));

    // ch1 exhausts its credits: 8 issues, then the FIFO fills.
    do_reset();
    drive_ch(1, 20, 12, 32'h100, n);
    check("exhaust issued", 64'(n), 64'(8));
    check("exhaust ready1", 64'(cpu_ready[1]), 64'(0));
    cpu_valid = 4'b0010;
    cpu_data[63:32] = 32'hDEAD;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("held tx_valid", 64'(tx_valid), 64'(0));
    end
    cpu_valid = '0;
    credit_ret = 4'b0010;
    tick();
    credit_ret = '0;
    check("ret edge tx_valid", 64'(tx_valid), 64'(0));
    tick();
    check("ret issue tx_valid", 64'(tx_valid), 64'(1));
    check("ret issue payload", 64'(tx_payload), 64'(32'h108));
    check("ret issue ready1", 64'(cpu_ready[1]), 64'(1));
    tick();
    check("ret one only", 64'(tx_valid), 64'(0));
    n = 0;
    for (int i = 0; i < 8; i++) begin
      credit_ret = (i < 3) ? 4'b0010 : 4'b0000;
      tick();
      if (tx_valid) begin
        check("ret3 payload", 64'(tx_payload), 64'(32'h109 + 32'(n)));
        n++;
      end
    end
    credit_ret = '0;
    check("ret3 count", 64'(n), 64'(3));

    // Credit return at the ceiling is ignored and flagged sticky.
    do_reset();
    credit_ret = 4'b0100;
    tick();
    credit_ret = '0;
    check("overflow err", 64'(credit_err), 64'(4'b0100));
    tick();
    tick();
    check("overflow sticky", 64'(credit_err), 64'(4'b0100));

    // ch3 grant and return in the same cycle at credit 5.
    do_reset();
    drive_ch(3, 6, 3, 32'h300, n);
    check("ch3 first issues", 64'(n), 64'(3));
    cpu_valid = 4'b1000;
    cpu_data[127:96] = 32'h303;
    tick();
    cpu_valid = '0;
    credit_ret = 4'b1000;
    tick();
    credit_ret = '0;
    check("same-cycle tx_valid", 64'(tx_valid), 64'(1));
    check("same-cycle payload", 64'(tx_payload), 64'(32'h303));
    drive_ch(3, 20, 8, 32'h304, n);
    check("credit kept at 5", 64'(n), 64'(5));
    check("same-cycle no err", 64'(credit_err), 64'(0));

    // Reset with 3 packets queued on ch0.
    do_reset();
    drive_ch(0, 20, 11, 32'h500, n);
    check("pre-rst issued", 64'(n), 64'(8));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid-rst tx_valid", 64'(tx_valid), 64'(0));
    check("mid-rst ready", 64'(cpu_ready), 64'(4'hF));
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (tx_valid) n++;
    end
    check("no stale issue", 64'(n), 64'(0));
    drive_ch(0, 20, 9, 32'h900, n);
    check("credits restored", 64'(n), 64'(8));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
